// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster generator.
//   vga_mode_e    : colour source selection
//   DEF_*         : 800x600@72 timing (horizontal in pixels, vertical in lines)
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SPLIT = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } vga_mode_e;

    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 56;
    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 37;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control-in / video-out bundle of the VGA raster generator.
//   master : generator side (takes pix_en/mode/code, drives sync, de, x, y,
//            frame_start and colour)
//   slave  : display controller / DAC side
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int COLOR_W = 4,
    parameter int XW      = 11,
    parameter int YW      = 10
);
    logic                   pix_en;
    vga_mode_e              mode;
    logic [6*COLOR_W-1:0]   code;
    logic                   hsync;
    logic                   vsync;
    logic                   de;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   frame_start;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;

    modport master (
        input  pix_en, mode, code,
        output hsync, vsync, de, x, y, frame_start, red, green, blue
    );

    modport slave (
        output pix_en, mode, code,
        input  hsync, vsync, de, x, y, frame_start, red, green, blue
    );
endinterface

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with raw (unregistered) sync and de.
//   clk, rst     : system clock, synchronous active-high reset
//   pix_en       : pixel strobe; counters move only when high
//   h, v         : current counter state
//   tick         : high the clk after any pix_en (state was just entered)
//   adv          : this pix_en advances the counters
//   h_wrap       : this pix_en wraps h back to 0
//   to_origin    : this pix_en enters h=0,v=0 (frame start)
//   origin       : state is h=0,v=0
//   hs_raw, vs_raw, de_raw : sync/de decoded from the current state
module vga_raster_cnt
    import vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1,
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HW    = $clog2(H_TOT),
    localparam int VW    = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          tick,
    output logic          adv,
    output logic          h_wrap,
    output logic          to_origin,
    output logic          origin,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          de_raw
);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [HW-1:0] HS_ON  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_OFF = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_ON  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_OFF = VW'(V_VIS + V_FP + V_SYNC);

    // The first pix_en after reset only arms the raster: it "enters" the
    // origin without moving, so the first frame starts at (0,0).
    logic run;
    logic h_last, v_last;

    assign h_last    = (h == H_LAST);
    assign v_last    = (v == V_LAST);
    assign adv       = pix_en & run;
    assign h_wrap    = adv & h_last;
    assign to_origin = pix_en & (~run | (h_last & v_last));
    assign origin    = (h == '0) && (v == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            h    <= '0;
            v    <= '0;
            run  <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= pix_en;
            if (pix_en) begin
                run <= 1'b1;
                if (run) begin
                    if (h_last) begin
                        h <= '0;
                        v <= v_last ? '0 : v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
            end
        end
    end

    assign hs_raw = (h >= HS_ON && h < HS_OFF) ? H_POL : ~H_POL;
    assign vs_raw = (v >= VS_ON && v < VS_OFF) ? V_POL : ~V_POL;
    assign de_raw = (h < H_VIS_C) && (v < V_VIS_C);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator top: raster counters, per-frame shadow of mode/code,
// colour source (split / solid / bars / checkerboard) and output registers.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : master side of vga_timing_gen_if (pix_en, mode, code in;
//              hsync, vsync, de, x, y, frame_start, red/green/blue out)
// All outputs load the clk after the counters change, so they stay mutually
// aligned and hold while pix_en is low.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS     = DEF_H_VIS,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VIS     = DEF_V_VIS,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int CHK_SHIFT = 5
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int CW3   = 3 * COLOR_W;
    localparam int AW    = $clog2(H_VIS + 8);
    localparam logic [HW-1:0] H_HALF = HW'(H_VIS / 2);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic tick, adv, h_wrap, to_origin, origin, hs_raw, vs_raw, de_raw;

    vga_raster_cnt #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL)
    ) u_cnt (
        .clk(clk), .rst(rst), .pix_en(bus.pix_en),
        .h(h), .v(v), .tick(tick), .adv(adv), .h_wrap(h_wrap),
        .to_origin(to_origin), .origin(origin),
        .hs_raw(hs_raw), .vs_raw(vs_raw), .de_raw(de_raw)
    );

    // Shadow registers: loaded on the same pix_en that enters (0,0), so a
    // whole frame is drawn with one mode/code.
    vga_mode_e          sh_mode;
    logic [2*CW3-1:0]   sh_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode <= MODE_SPLIT;
            sh_code <= '0;
        end else if (to_origin) begin
            sh_mode <= bus.mode;
            sh_code <= bus.code;
        end
    end

    // Bar index = h*8/H_VIS without a divider: acc holds h*8 - bar*H_VIS and
    // stays below H_VIS, tracking h step for step. Saturates past the last bar.
    logic [AW-1:0] acc, acc_nx;
    logic [2:0]    bar;

    assign acc_nx = acc + AW'(8);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            bar <= '0;
        end else if (h_wrap) begin
            acc <= '0;
            bar <= '0;
        end else if (adv) begin
            if (acc_nx >= AW'(H_VIS)) begin
                acc <= acc_nx - AW'(H_VIS);
                if (bar != 3'd7) bar <= bar + 3'd1;
            end else begin
                acc <= acc_nx;
            end
        end
    end

    // Colour source
    logic [CW3-1:0] col_a, col_b, pix;

    assign col_a = sh_code[2*CW3-1:CW3];
    assign col_b = sh_code[CW3-1:0];

    always_comb begin
        pix = '0;
        case (sh_mode)
            MODE_SPLIT: pix = (h < H_HALF) ? col_a : col_b;
            MODE_SOLID: pix = col_a;
            MODE_BARS:  pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
            MODE_CHECK: pix = (h[CHK_SHIFT] ^ v[CHK_SHIFT]) ? col_b : col_a;
            default:    pix = '0;
        endcase
        if (!de_raw) pix = '0;
    end

    // Output registers
    logic           hsync_q, vsync_q, de_q, fs_q;
    logic [HW-1:0]  x_q;
    logic [VW-1:0]  y_q;
    logic [CW3-1:0] rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            // tick is a single clk, so frame_start stays one clk wide even
            // when the origin state is held across several clks.
            fs_q <= tick & origin;
            if (tick) begin
                hsync_q <= hs_raw;
                vsync_q <= vs_raw;
                de_q    <= de_raw;
                x_q     <= h;
                y_q     <= v;
                rgb_q   <= pix;
            end
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.frame_start = fs_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign bus.green       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign bus.blue        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (24x13) with both sync polarities.
// The reference model counts pixel strobes since reset and derives the raster
// position, sync, de and colour arithmetically from that count.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int CW = 4, CS = 2;
    localparam int XW = $clog2(H_TOT), YW = $clog2(V_TOT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.COLOR_W(CW), .XW(XW), .YW(YW)) bus_p ();
    vga_timing_gen_if #(.COLOR_W(CW), .XW(XW), .YW(YW)) bus_n ();

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(CW), .CHK_SHIFT(CS)
    ) dut (.clk(clk), .rst(rst), .bus(bus_p));

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(CW), .CHK_SHIFT(CS)
    ) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    logic [39:0] got_p, got_n;
    assign got_p = {bus_p.hsync, bus_p.vsync, bus_p.de, bus_p.frame_start,
                    12'(bus_p.x), 12'(bus_p.y), bus_p.red, bus_p.green, bus_p.blue};
    assign got_n = {bus_n.hsync, bus_n.vsync, bus_n.de, bus_n.frame_start,
                    12'(bus_n.x), 12'(bus_n.y), bus_n.red, bus_n.green, bus_n.blue};

    int checks = 0, errors = 0, tcnt = 0;

    // Inputs presented to both DUTs
    vga_mode_e   md = MODE_SPLIT;
    logic [23:0] cd = '0;

    // Reference model state
    int          cnt = -1;          // index of the latest accepted strobe
    bit          upd_prev = 0;
    bit          shown_valid = 0;
    int          shown_p = 0;
    bit          fs_exp = 0;
    vga_mode_e   sh_mode = MODE_SPLIT, shown_mode = MODE_SPLIT;
    logic [23:0] sh_code = '0, shown_code = '0;

    function automatic logic [39:0] exp_vec(input bit hp, input bit vp);
        int h, v;
        bit hs, vs, de;
        logic [11:0] rgb, ca, cb;
        logic [2:0] bi;
        if (!shown_valid) return {~hp, ~vp, 2'b00, 36'h0};
        h  = shown_p % H_TOT;
        v  = (shown_p / H_TOT) % V_TOT;
        hs = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? hp : ~hp;
        vs = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? vp : ~vp;
        de = (h < H_VIS) && (v < V_VIS);
        ca = shown_code[23:12];
        cb = shown_code[11:0];
        rgb = '0;
        if (de) begin
            case (shown_mode)
                MODE_SPLIT: rgb = (h < H_VIS / 2) ? ca : cb;
                MODE_SOLID: rgb = ca;
                MODE_BARS: begin
                    bi  = 3'(h * 8 / H_VIS);
                    rgb = {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
                end
                default: rgb = ((((h >> CS) ^ (v >> CS)) & 1) == 0) ? ca : cb;
            endcase
        end
        return {hs, vs, de, fs_exp, 12'(h), 12'(v), rgb};
    endfunction

    // One clk: drive inputs, advance the model, settle past the edge.
    task automatic step(input bit pe, input bit r);
        bus_p.pix_en = pe;  bus_n.pix_en = pe;
        bus_p.mode   = md;  bus_n.mode   = md;
        bus_p.code   = cd;  bus_n.code   = cd;
        rst = r;
        @(posedge clk);
        if (r) begin
            cnt = -1; upd_prev = 0; shown_valid = 0; fs_exp = 0;
            sh_mode = MODE_SPLIT; sh_code = '0;
        end else begin
            fs_exp = 0;
            if (upd_prev) begin
                shown_p     = cnt;
                shown_valid = 1;
                shown_mode  = sh_mode;
                shown_code  = sh_code;
                fs_exp      = (cnt % FRAME == 0);
            end
            if (pe) begin
                cnt++;
                if (cnt % FRAME == 0) begin
                    sh_mode = md;
                    sh_code = cd;
                end
            end
            upd_prev = pe;
        end
        #1;
        tcnt++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, i < 3);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL reset[%0d]: pos got %h exp %h, neg got %h exp %h",
                         i, got_p, exp_vec(1, 1), got_n, exp_vec(0, 0));
            end
        end
    endtask

    task automatic test_frame_timing();
        int hrun = 0, vrun = 0, last_fs = -1, nfs = 0;
        bit hs_prev, vs_prev;
        md = MODE_SOLID;
        cd = 24'($urandom);
        hs_prev = bus_p.hsync;
        vs_prev = bus_p.vsync;
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL timing t=%0d: pos got %h exp %h, neg got %h exp %h",
                         tcnt, got_p, exp_vec(1, 1), got_n, exp_vec(0, 0));
            end
            if (bus_p.hsync && !hs_prev) hrun = 1;
            else if (bus_p.hsync && hrun > 0) hrun++;
            if (!bus_p.hsync && hs_prev && hrun > 0) begin
                checks++;
                if (hrun != H_SYNC) begin
                    errors++;
                    $display("FAIL hsync_width: got %0d clks exp %0d", hrun, H_SYNC);
                end
                hrun = 0;
            end
            hs_prev = bus_p.hsync;
            if (bus_p.vsync && !vs_prev) vrun = 1;
            else if (bus_p.vsync && vrun > 0) vrun++;
            if (!bus_p.vsync && vs_prev && vrun > 0) begin
                checks++;
                if (vrun != V_SYNC * H_TOT) begin
                    errors++;
                    $display("FAIL vsync_width: got %0d clks exp %0d", vrun, V_SYNC * H_TOT);
                end
                vrun = 0;
            end
            vs_prev = bus_p.vsync;
            if (bus_p.frame_start) begin
                nfs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (tcnt - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d clks exp %0d", tcnt - last_fs, FRAME);
                    end
                end
                last_fs = tcnt;
            end
        end
        checks++;
        if (nfs < 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d exp >= 2", nfs);
        end
    endtask

    task automatic test_split();
        bit seen = 0;
        logic [11:0] want;
        md = MODE_SPLIT;
        cd = 24'hF00_0F0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL split t=%0d: pos got %h exp %h", tcnt, got_p, exp_vec(1, 1));
            end
            if (bus_p.frame_start) seen = 1;
            if (seen) begin
                want = !bus_p.de ? 12'h000 : (bus_p.x < XW'(H_VIS / 2)) ? 12'hF00 : 12'h0F0;
                checks++;
                if (got_p[11:0] !== want) begin
                    errors++;
                    $display("FAIL split_rgb x=%0d y=%0d: got %h exp %h",
                             bus_p.x, bus_p.y, got_p[11:0], want);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        int n;
        logic [11:0] want;
        n = 0;
        while (!(bus_p.y == YW'(4) && bus_p.x == '0) && n < 2 * FRAME) begin
            step(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL mode_change_wait: row 4 not reached in %0d clks", n);
        end
        md = MODE_BARS;
        n = 0;
        while (!bus_p.frame_start && n < FRAME + 4) begin
            step(1'b1, 1'b0);
            n++;
            checks++;
            if (got_p !== exp_vec(1, 1)) begin
                errors++;
                $display("FAIL mode_hold t=%0d: got %h exp %h", tcnt, got_p, exp_vec(1, 1));
            end
            if (bus_p.de && !bus_p.frame_start) begin
                want = (bus_p.x < XW'(H_VIS / 2)) ? 12'hF00 : 12'h0F0;
                checks++;
                if (got_p[11:0] !== want) begin
                    errors++;
                    $display("FAIL mode_no_tear x=%0d y=%0d: got %h exp %h",
                             bus_p.x, bus_p.y, got_p[11:0], want);
                end
            end
        end
        checks++;
        if (!bus_p.frame_start) begin
            errors++;
            $display("FAIL mode_change_fs: no frame_start within %0d clks", n);
        end
        for (int i = 0; i < H_TOT; i++) begin
            if (i > 0) step(1'b1, 1'b0);
            checks++;
            if (got_p !== exp_vec(1, 1)) begin
                errors++;
                $display("FAIL bars t=%0d: got %h exp %h", tcnt, got_p, exp_vec(1, 1));
            end
            if (bus_p.x < XW'(2) || bus_p.x >= XW'(H_VIS - 2)) begin
                if (bus_p.x < XW'(H_VIS)) begin
                    want = (bus_p.x < XW'(2)) ? 12'h000 : 12'hFFF;
                    checks++;
                    if (got_p[11:0] !== want) begin
                        errors++;
                        $display("FAIL bars_edge x=%0d: got %h exp %h", bus_p.x, got_p[11:0], want);
                    end
                end
            end
        end
    endtask

    task automatic test_sparse_pix_en();
        int hrun = 0, last_fs = -1;
        bit hs_prev;
        md = MODE_CHECK;
        cd = 24'($urandom);
        hs_prev = bus_p.hsync;
        for (int i = 0; i < 8 * FRAME + 20; i++) begin
            step(i % 4 == 0, 1'b0);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL sparse t=%0d: pos got %h exp %h, neg got %h exp %h",
                         tcnt, got_p, exp_vec(1, 1), got_n, exp_vec(0, 0));
            end
            if (bus_p.hsync && !hs_prev) hrun = 1;
            else if (bus_p.hsync && hrun > 0) hrun++;
            if (!bus_p.hsync && hs_prev && hrun > 0) begin
                checks++;
                if (hrun != 4 * H_SYNC) begin
                    errors++;
                    $display("FAIL sparse_hsync_width: got %0d clks exp %0d", hrun, 4 * H_SYNC);
                end
                hrun = 0;
            end
            hs_prev = bus_p.hsync;
            if (bus_p.frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (tcnt - last_fs != 4 * FRAME) begin
                        errors++;
                        $display("FAIL sparse_frame_period: got %0d exp %0d", tcnt - last_fs, 4 * FRAME);
                    end
                end
                last_fs = tcnt;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(bus_p.x == XW'(10) && bus_p.y == YW'(5)) && n < 2 * FRAME) begin
            step(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL reset_mid_wait: position not reached in %0d clks", n);
        end
        for (int i = 0; i < 6; i++) begin
            step(i == 3, i == 0);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL reset_mid[%0d]: pos got %h exp %h, neg got %h exp %h",
                         i, got_p, exp_vec(1, 1), got_n, exp_vec(0, 0));
            end
            checks++;
            if (bus_p.frame_start !== (i == 4)) begin
                errors++;
                $display("FAIL reset_mid_fs[%0d]: got %b exp %b", i, bus_p.frame_start, i == 4);
            end
        end
    endtask

    task automatic test_random();
        bit r;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) md = vga_mode_e'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) cd = 24'($urandom);
            r = ($urandom_range(0, 699) == 0);
            step($urandom_range(0, 2) != 0, r);
            checks++;
            if (got_p !== exp_vec(1, 1) || got_n !== exp_vec(0, 0)) begin
                errors++;
                $display("FAIL random t=%0d: pos got %h exp %h, neg got %h exp %h",
                         tcnt, got_p, exp_vec(1, 1), got_n, exp_vec(0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_split();
        test_mode_change();
        test_sparse_pix_en();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
